// File: rtl/caminho_fifo_saida.sv
// caminho_fifo_saida: output stage after gerenciador_memoria_anterior.
// Buffers the path nodes emitted during reconstruction and presents them to the
// host on a first-word-fall-through valid/ready stream. It also provides an
// end-of-path marker, the path length and a sticky overflow flag.
// Optional build macro: CAMINHO_INVERTER_EN turns the buffer into a LIFO. The
// path then comes out fonte->destino and is only released after reconstruction.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module caminho_fifo_saida #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  top_wr_fonte_in,
    input  logic [ADDR_WIDTH-1:0] top_fonte_in,
    input  logic [ADDR_WIDTH-1:0] gma_read_data_in,
    input  logic                  gma_valido_in,
    input  logic                  gma_pronto_in,
    output logic                  gma_parar_out,
    output logic [ADDR_WIDTH-1:0] caminho_data_out,
    output logic                  caminho_valid_out,
    input  logic                  caminho_ready_in,
    output logic                  caminho_ultimo_out,
    output logic [LEN_WIDTH-1:0]  caminho_tamanho_out,
    output logic                  caminho_erro_out,
    output logic                  caminho_ocioso_out
);

    typedef enum logic [1:0] {
        StOcioso     = 2'd0,
        StColetando  = 2'd1,
        StEsvaziando = 2'd2,
        StErro       = 2'd3
    } estado_t;

    estado_t                r_estado;
    estado_t                w_estado_d;

    logic [ADDR_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH:0]     r_ocup;
    logic [LEN_WIDTH-1:0]   r_tamanho;
    logic                   r_erro;

    logic                   w_cheio;
    logic                   w_vazio;
    logic                   w_valid;
    logic                   w_pop;
    logic                   w_tenta;
    logic                   w_espaco;
    logic                   w_push;
    logic                   w_estouro;
    logic [PTR_WIDTH-1:0]   w_end_wr;
    logic [PTR_WIDTH-1:0]   w_end_rd;
    logic [ADDR_WIDTH-1:0]  w_cabeca;

    // The fonte address is only relevant upstream; it is kept on the port for
    // interface compatibility.
    logic                   w_unused;
    assign w_unused = ^top_fonte_in;

    assign w_cheio = (r_ocup == (PTR_WIDTH+1)'(FIFO_DEPTH));
    assign w_vazio = (r_ocup == '0);

    // A write is only attempted while collecting; a start in the same cycle wins.
    assign w_tenta   = gma_valido_in & ~top_wr_fonte_in & (r_estado == StColetando);
    assign w_push    = w_tenta & w_espaco;
    assign w_estouro = w_tenta & ~w_espaco;

`ifdef CAMINHO_INVERTER_EN
    // Stack: occupancy doubles as the stack pointer, head is the last node written.
    assign w_end_wr = r_ocup[PTR_WIDTH-1:0];
    assign w_end_rd = r_ocup[PTR_WIDTH-1:0] - PTR_WIDTH'(1);
    // No pops happen while collecting, so a full stack never has room.
    assign w_espaco = ~w_cheio;
`else
    logic [PTR_WIDTH-1:0]   r_wr_ptr;
    logic [PTR_WIDTH-1:0]   r_rd_ptr;

    assign w_end_wr = r_wr_ptr;
    assign w_end_rd = r_rd_ptr;
    // A pop in the same cycle frees the slot the push needs.
    assign w_espaco = ~w_cheio | w_pop;

    // Ring pointers; they wrap naturally modulo FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (top_wr_fonte_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
        end
    end
`endif

    assign w_cabeca = r_mem[w_end_rd];

    // Storage array; contents need no reset because valid gates the output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_end_wr] <= gma_read_data_in;
        end
    end

    // Occupancy counter; full/empty are derived from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ocup <= '0;
        end else if (top_wr_fonte_in) begin
            r_ocup <= '0;
        end else if (w_push && !w_pop) begin
            r_ocup <= r_ocup + (PTR_WIDTH+1)'(1);
        end else if (w_pop && !w_push) begin
            r_ocup <= r_ocup - (PTR_WIDTH+1)'(1);
        end
    end

    // Path length (saturating) and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tamanho <= '0;
            r_erro    <= 1'b0;
        end else if (top_wr_fonte_in) begin
            r_tamanho <= '0;
            r_erro    <= 1'b0;
        end else begin
            if (w_push && (r_tamanho != '1)) begin
                r_tamanho <= r_tamanho + LEN_WIDTH'(1);
            end
            if (w_estouro) begin
                r_erro <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= StOcioso;
        end else begin
            r_estado <= w_estado_d;
        end
    end

    // FSM next-state logic; a new search start overrides every state.
    always_comb begin
        w_estado_d = r_estado;
        if (top_wr_fonte_in) begin
            w_estado_d = StColetando;
        end else begin
            unique case (r_estado)
                StOcioso: begin
                    w_estado_d = StOcioso;
                end
                StColetando: begin
                    if (w_estouro) begin
                        w_estado_d = StErro;
                    end else if (gma_pronto_in) begin
                        w_estado_d = StEsvaziando;
                    end
                end
                StEsvaziando: begin
                    // Leave once the buffer is (or is about to be) empty.
                    if (w_vazio || (w_pop && (r_ocup == (PTR_WIDTH+1)'(1)))) begin
                        w_estado_d = StOcioso;
                    end
                end
                StErro: begin
                    w_estado_d = StErro;
                end
                default: begin
                    w_estado_d = StOcioso;
                end
            endcase
        end
    end

    // FSM and stream outputs.
    always_comb begin
`ifdef CAMINHO_INVERTER_EN
        w_valid       = ~w_vazio & (r_estado == StEsvaziando);
        w_pop         = w_valid & caminho_ready_in;
        gma_parar_out = w_cheio;
`else
        w_valid       = ~w_vazio & (r_estado != StOcioso);
        w_pop         = w_valid & caminho_ready_in;
        gma_parar_out = w_cheio & ~w_pop;
`endif
        caminho_valid_out   = w_valid;
        caminho_data_out    = w_valid ? w_cabeca : '0;
        caminho_ultimo_out  = w_valid & (r_estado == StEsvaziando) &
                              (r_ocup == (PTR_WIDTH+1)'(1));
        caminho_tamanho_out = r_tamanho;
        caminho_erro_out    = r_erro;
        caminho_ocioso_out  = (r_estado == StOcioso);
    end

endmodule

// File: tb/tb_caminho_fifo_saida.sv
// Bench for caminho_fifo_saida: a table of vectors for the basic path, hand
// sequences for overflow/full/restart/reset, and random traffic checked
// against a queue-based model of the path buffer.
`timescale 1ns/1ps

module tb_caminho_fifo_saida;

    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = AW + 1;
`ifdef CAMINHO_INVERTER_EN
    localparam bit LIFO = 1'b1;
`else
    localparam bit LIFO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          top_wr_fonte_in;
    logic [AW-1:0] top_fonte_in;
    logic [AW-1:0] gma_read_data_in;
    logic          gma_valido_in;
    logic          gma_pronto_in;
    logic          gma_parar_out;
    logic [AW-1:0] caminho_data_out;
    logic          caminho_valid_out;
    logic          caminho_ready_in;
    logic          caminho_ultimo_out;
    logic [LW-1:0] caminho_tamanho_out;
    logic          caminho_erro_out;
    logic          caminho_ocioso_out;

    caminho_fifo_saida #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .top_wr_fonte_in     (top_wr_fonte_in),
        .top_fonte_in        (top_fonte_in),
        .gma_read_data_in    (gma_read_data_in),
        .gma_valido_in       (gma_valido_in),
        .gma_pronto_in       (gma_pronto_in),
        .gma_parar_out       (gma_parar_out),
        .caminho_data_out    (caminho_data_out),
        .caminho_valid_out   (caminho_valid_out),
        .caminho_ready_in    (caminho_ready_in),
        .caminho_ultimo_out  (caminho_ultimo_out),
        .caminho_tamanho_out (caminho_tamanho_out),
        .caminho_erro_out    (caminho_erro_out),
        .caminho_ocioso_out  (caminho_ocioso_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nome, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {MIdle, MCollect, MDrain, MErr} fase_t;
    fase_t         m_fase;
    logic [AW-1:0] m_q[$];
    int            m_tam;
    bit            m_erro;

    function automatic void m_reset();
        m_q.delete();
        m_fase = MIdle;
        m_tam  = 0;
        m_erro = 1'b0;
    endfunction

    function automatic bit m_valid();
        if (m_q.size() == 0) return 1'b0;
        return LIFO ? (m_fase == MDrain) : (m_fase != MIdle);
    endfunction

    task automatic check_outputs(input string tag);
        bit            v;
        bit            pop;
        bit            full;
        logic [AW-1:0] d;
        v    = m_valid();
        d    = v ? (LIFO ? m_q[$] : m_q[0]) : '0;
        pop  = v && caminho_ready_in;
        full = (m_q.size() == DEPTH);
        chk({tag, ".valid"},   caminho_valid_out, v);
        chk({tag, ".data"},    caminho_data_out, d);
        chk({tag, ".ultimo"},  caminho_ultimo_out, v && m_fase == MDrain && m_q.size() == 1);
        chk({tag, ".tamanho"}, caminho_tamanho_out, m_tam);
        chk({tag, ".erro"},    caminho_erro_out, m_erro);
        chk({tag, ".ocioso"},  caminho_ocioso_out, m_fase == MIdle);
        chk({tag, ".parar"},   gma_parar_out, LIFO ? full : (full && !pop));
    endtask

    // Applies one clock edge worth of the path-buffer rules to the model.
    function automatic void m_update();
        fase_t f0;
        bit    pop;
        if (top_wr_fonte_in) begin
            m_q.delete();
            m_tam  = 0;
            m_erro = 1'b0;
            m_fase = MCollect;
            return;
        end
        f0  = m_fase;
        pop = m_valid() && caminho_ready_in;
        if (pop) begin
            if (LIFO) void'(m_q.pop_back());
            else      void'(m_q.pop_front());
        end
        if (gma_valido_in && f0 == MCollect) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(gma_read_data_in);
                if (m_tam < (1 << LW) - 1) m_tam++;
            end else begin
                m_erro = 1'b1;
                m_fase = MErr;
            end
        end
        if (f0 == MCollect && m_fase != MErr && gma_pronto_in) m_fase = MDrain;
        if (f0 == MDrain && m_q.size() == 0) m_fase = MIdle;
    endfunction

    // Drive inputs just after an edge, check at the falling edge, advance model.
    task automatic step(input bit st, input bit vin, input logic [AW-1:0] d,
                        input bit pr, input bit rdy, input string tag, output bit popped);
        top_wr_fonte_in  = st;
        gma_valido_in    = vin;
        gma_read_data_in = d;
        gma_pronto_in    = pr;
        caminho_ready_in = rdy;
        @(negedge clk);
        popped = caminho_valid_out && caminho_ready_in;
        check_outputs(tag);
        @(posedge clk);
        m_update();
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            st;
        bit            vin;
        logic [AW-1:0] d;
        bit            pr;
        bit            rdy;
        bit            e_valid;
        logic [AW-1:0] e_data;
        bit            e_ult;
        int            e_tam;
        bit            e_erro;
        bit            e_ocio;
        bit            e_parar;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit p;
        int n;

`ifdef CAMINHO_INVERTER_EN
        vecs[0] = '{1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0, 1, 0};
        vecs[1] = '{0, 1, 8'h05, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 1, 8'h09, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0};
        vecs[3] = '{0, 1, 8'h0C, 1, 0,  0, 8'h00, 0, 2, 0, 0, 0};
        vecs[4] = '{0, 0, 8'h00, 1, 1,  1, 8'h0C, 0, 3, 0, 0, 0};
        vecs[5] = '{0, 0, 8'h00, 1, 1,  1, 8'h09, 0, 3, 0, 0, 0};
        vecs[6] = '{0, 0, 8'h00, 1, 1,  1, 8'h05, 1, 3, 0, 0, 0};
        vecs[7] = '{0, 0, 8'h00, 1, 1,  0, 8'h00, 0, 3, 0, 1, 0};
`else
        vecs[0] = '{1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0, 1, 0};
        vecs[1] = '{0, 1, 8'h05, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 1, 8'h09, 0, 0,  1, 8'h05, 0, 1, 0, 0, 0};
        vecs[3] = '{0, 1, 8'h0C, 1, 0,  1, 8'h05, 0, 2, 0, 0, 0};
        vecs[4] = '{0, 0, 8'h00, 1, 1,  1, 8'h05, 0, 3, 0, 0, 0};
        vecs[5] = '{0, 0, 8'h00, 1, 1,  1, 8'h09, 0, 3, 0, 0, 0};
        vecs[6] = '{0, 0, 8'h00, 1, 1,  1, 8'h0C, 1, 3, 0, 0, 0};
        vecs[7] = '{0, 0, 8'h00, 1, 1,  0, 8'h00, 0, 3, 0, 1, 0};
`endif

        rst              = 1'b1;
        top_wr_fonte_in  = 1'b0;
        top_fonte_in     = 8'h3A;
        gma_read_data_in = '0;
        gma_valido_in    = 1'b0;
        gma_pronto_in    = 1'b0;
        caminho_ready_in = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid",   caminho_valid_out, 1'b0);
        chk("reset.data",    caminho_data_out, 8'h00);
        chk("reset.ultimo",  caminho_ultimo_out, 1'b0);
        chk("reset.tamanho", caminho_tamanho_out, 0);
        chk("reset.erro",    caminho_erro_out, 1'b0);
        chk("reset.ocioso",  caminho_ocioso_out, 1'b1);
        chk("reset.parar",   gma_parar_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic three-node path from the table.
        for (int i = 0; i < 8; i++) begin
            top_wr_fonte_in  = vecs[i].st;
            gma_valido_in    = vecs[i].vin;
            gma_read_data_in = vecs[i].d;
            gma_pronto_in    = vecs[i].pr;
            caminho_ready_in = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d.valid", i),   caminho_valid_out, vecs[i].e_valid);
            chk($sformatf("vec%0d.data", i),    caminho_data_out, vecs[i].e_data);
            chk($sformatf("vec%0d.ultimo", i),  caminho_ultimo_out, vecs[i].e_ult);
            chk($sformatf("vec%0d.tamanho", i), caminho_tamanho_out, vecs[i].e_tam);
            chk($sformatf("vec%0d.erro", i),    caminho_erro_out, vecs[i].e_erro);
            chk($sformatf("vec%0d.ocioso", i),  caminho_ocioso_out, vecs[i].e_ocio);
            chk($sformatf("vec%0d.parar", i),   gma_parar_out, vecs[i].e_parar);
            @(posedge clk);
            m_update();
            #1;
        end

        // Fill to 16 with the host stalled, then overflow with a 17th node.
        step(1, 0, 8'h00, 0, 0, "ovf.start", p);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h40 + i), 0, 0, "ovf.fill", p);
        top_wr_fonte_in = 1'b0;
        gma_valido_in   = 1'b0;
        #1;
        chk("ovf.parar_full", gma_parar_out, 1'b1);
        step(0, 1, 8'hEE, 0, 0, "ovf.extra", p);
        chk("ovf.erro", caminho_erro_out, 1'b1);
        chk("ovf.not_idle", caminho_ocioso_out, 1'b0);
        n = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            step(0, 1, 8'h77, 1, 1, "ovf.drain", p);
            if (p) n++;
        end
        chk("ovf.drained", n, LIFO ? 0 : DEPTH);
        chk("ovf.erro_sticky", caminho_erro_out, 1'b1);

        // Full buffer with push and pop in the same cycle.
        step(1, 0, 8'h00, 0, 0, "full.start", p);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h80 + i), 0, 0, "full.fill", p);
        step(0, 1, 8'h99, 0, 1, "full.pushpop", p);
        chk("full.no_erro", caminho_erro_out, LIFO ? 1'b1 : 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 8'h00, 1, 1, "full.drain", p);

        // Restart while in error with 4 nodes still buffered.
        step(1, 0, 8'h00, 0, 0, "rst5.start", p);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'hC0 + i), 0, 0, "rst5.fill", p);
        step(0, 1, 8'hEE, 0, 0, "rst5.extra", p);
        for (int i = 0; i < DEPTH - 4; i++) step(0, 0, 8'h00, 0, 1, "rst5.drain", p);
        step(1, 1, 8'h55, 0, 0, "rst5.restart", p);
        gma_valido_in    = 1'b0;
        top_wr_fonte_in  = 1'b0;
        #1;
        chk("rst5.valid",   caminho_valid_out, 1'b0);
        chk("rst5.tamanho", caminho_tamanho_out, 0);
        chk("rst5.erro",    caminho_erro_out, 1'b0);
        chk("rst5.ocioso",  caminho_ocioso_out, 1'b0);

        // Asynchronous reset in the middle of collecting three nodes.
        step(0, 1, 8'h11, 0, 0, "arst.push", p);
        step(0, 1, 8'h22, 0, 0, "arst.push", p);
        step(0, 1, 8'h33, 0, 0, "arst.push", p);
        gma_valido_in = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst.valid",   caminho_valid_out, 1'b0);
        chk("arst.data",    caminho_data_out, 8'h00);
        chk("arst.tamanho", caminho_tamanho_out, 0);
        chk("arst.ocioso",  caminho_ocioso_out, 1'b1);
        chk("arst.parar",   gma_parar_out, 1'b0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic against the model.
        begin
            bit pr_level = 1'b0;
            int rp = 50;
            for (int c = 0; c < 4000; c++) begin
                bit st;
                if (c % 100 == 0) rp = (c % 300 == 0) ? 10 : ((c % 300 == 100) ? 50 : 90);
                st = ($urandom_range(0, 63) == 0);
                if (st) pr_level = 1'b0;
                else if ($urandom_range(0, 29) == 0) pr_level = 1'b1;
                step(st, 1'($urandom), 8'($urandom), pr_level,
                     ($urandom_range(0, 99) < rp), "rand", p);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/caminho_fifo_saida.md
Name: caminho_fifo_saida

Overview:
- Output stage directly downstream of gerenciador_memoria_anterior.
- Accepts the path nodes the memory manager emits during path reconstruction, one address per strobe, walking from destino back to fonte.
- Buffers the nodes and presents them to the external host on a valid/ready stream, with an end-of-path marker, a length count and overflow detection.
- Lets the host read the path at its own pace without stalling the search core.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH — node address width.
- FIFO_DEPTH, 16 — buffer entries; must be a power of 2, minimum 2.
- PTR_WIDTH, $clog2(FIFO_DEPTH) — pointer width (derived).
- LEN_WIDTH, ADDR_WIDTH+1 — width of the path-length counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- top_wr_fonte_in  in  1  new search start; soft clear of buffer and flags.
- top_fonte_in  in  ADDR_WIDTH  registered fonte address.
- gma_read_data_in  in  ADDR_WIDTH  path node from the memory manager.
- gma_valido_in  in  1  gma_read_data_in valid this cycle.
- gma_pronto_in  in  1  path reconstruction finished (level, held until next start).
- gma_parar_out  out  1  backpressure to the memory manager (buffer full).
- caminho_data_out  out  ADDR_WIDTH  head node.
- caminho_valid_out  out  1  head node valid.
- caminho_ready_in  in  1  host accepts head node.
- caminho_ultimo_out  out  1  head node is the last of the path.
- caminho_tamanho_out  out  LEN_WIDTH  nodes accepted in the current path.
- caminho_erro_out  out  1  sticky overflow flag.
- caminho_ocioso_out  out  1  FSM in OCIOSO.

Behaviour:
- Reset (rst=1, async):
  - FSM=OCIOSO; pointers and occupancy=0.
  - All outputs 0 except caminho_ocioso_out=1.
  - caminho_data_out=0.
- FSM states: OCIOSO, COLETANDO, ESVAZIANDO, ERRO.
- OCIOSO→COLETANDO on top_wr_fonte_in.
- top_wr_fonte_in in any state:
  - Next cycle: empty buffer, clear tamanho and erro, state=COLETANDO.
  - A simultaneous gma_valido_in is ignored.
- COLETANDO:
  - Each gma_valido_in with buffer not full writes gma_read_data_in and increments tamanho.
  - tamanho saturates at all-ones.
  - gma_pronto_in=1 → ESVAZIANDO next cycle; a valid in that same cycle is still written.
- Write while full (gma_valido_in=1 and full, parar ignored):
  - Data dropped; caminho_erro_out=1 next cycle; state→ERRO.
  - ERRO: writes blocked, reads continue, erro stays 1.
  - Exit ERRO only via top_wr_fonte_in or rst.
- ESVAZIANDO: writes ignored; returns to OCIOSO the cycle after the last pop empties the buffer.
- Output (first-word-fall-through):
  - caminho_valid_out = (occupancy≠0) in COLETANDO/ESVAZIANDO/ERRO.
  - caminho_data_out = head entry, combinational from buffer.
  - Pop when valid & ready.
- caminho_ultimo_out = valid & state==ESVAZIANDO & occupancy==1.
- Simultaneous push and pop: occupancy unchanged; not full for the push if a pop occurs in the same cycle.
- gma_parar_out = full & !pop.
- Latency: a node written at edge N is visible on caminho_valid_out after edge N (1 cycle).
- Pointers wrap modulo FIFO_DEPTH. Full/empty come from an occupancy counter of PTR_WIDTH+1 bits.
- Valid/data must hold stable while !ready.

Optional Feature:
- Macro: CAMINHO_INVERTER_EN.
- Defined:
  - Buffer operates as a LIFO, so output order is fonte→destino.
  - caminho_valid_out is forced 0 until state==ESVAZIANDO; no streaming during COLETANDO.
  - gma_parar_out = full.
  - caminho_ultimo_out marks the first-written node (destino), i.e. the final pop.
- Undefined: FIFO order destino→fonte with streaming as above.

Test Plan:
1. rst=1 mid-COLETANDO holding 3 nodes → next cycle all outputs 0, caminho_ocioso_out=1, valid=0.
2. Start, push 0x05,0x09,0x0C then gma_pronto_in, ready=1 → out 0x05,0x09,0x0C; ultimo only on 0x0C; tamanho=3; then OCIOSO.
3. ready=0, push 16 nodes → gma_parar_out=1 after 16th; a 17th valid → erro=1, ERRO state; ready=1 drains exactly 16 nodes.
4. Full buffer, push and pop in the same cycle → no error, occupancy stays 16, data order preserved.
5. top_wr_fonte_in while 4 nodes buffered and erro=1 → next cycle valid=0, tamanho=0, erro=0, state=COLETANDO.
6. CAMINHO_INVERTER_EN defined, push 0x05,0x09,0x0C, pronto → valid stays 0 before pronto; output 0x0C,0x09,0x05 with ultimo on 0x05.
